// File: rtl/cond_wait_responder_if.sv
// rtl/cond_wait_responder_if.sv - request/completion bundle for the condition-wait responder
//
// Signals:
//   req_valid / req_ready   request handshake (initiator -> responder)
//   req_target, req_mode    target sum and mode (0 = edge, 1 = level)
//   cancel                  abandon an armed wait
//   busy_o                  responder is not idle
//   fire_o                  one-cycle completion pulse
//   fire_sum                sum captured at detection, held until next fire
//   timeout_o               qualifies fire_o as a timeout completion
// Modports: master = initiator side, slave = responder side.

interface cond_wait_responder_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_target;
    logic             req_mode;
    logic             cancel;
    logic             busy_o;
    logic             fire_o;
    logic [WIDTH-1:0] fire_sum;
    logic             timeout_o;

    modport master (
        output req_valid, req_target, req_mode, cancel,
        input  req_ready, busy_o, fire_o, fire_sum, timeout_o
    );

    modport slave (
        input  req_valid, req_target, req_mode, cancel,
        output req_ready, busy_o, fire_o, fire_sum, timeout_o
    );
endinterface

// File: rtl/cond_wait_responder.sv
// rtl/cond_wait_responder.sv - responder for condition waits on (a + b == target)
//
// Owns operands a/b, accepts one wait request at a time and emits a one-cycle
// fire pulse when the watched condition is satisfied.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   load, load_a, load_b  load operands (has priority over step)
//   step, inc_a, inc_b    a += inc_a, b += inc_b (wrapping)
//   a_o, b_o, sum_o       current operands and their wrapped sum
//   bus (slave)           request handshake, cancel, busy/fire/fire_sum/timeout
//
// Optional feature macro: COND_WAIT_TIMEOUT_EN
//   defined   - an armed wait is forced to fire with timeout_o=1 after
//               TIMEOUT_CYCLES armed cycles without detection or cancel
//   undefined - no counter, timeout_o is 0, armed waits are unbounded

module cond_wait_responder #(
    parameter int               WIDTH          = 32,
    parameter logic [WIDTH-1:0] A_INIT         = WIDTH'(8),
    parameter logic [WIDTH-1:0] B_INIT         = WIDTH'(4),
    parameter int               TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_a,
    input  logic [WIDTH-1:0]     load_b,
    input  logic                 step,
    input  logic [WIDTH-1:0]     inc_a,
    input  logic [WIDTH-1:0]     inc_b,
    output logic [WIDTH-1:0]     a_o,
    output logic [WIDTH-1:0]     b_o,
    output logic [WIDTH-1:0]     sum_o,
    cond_wait_responder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] target_q;
    logic             mode_q;
    logic             cond_prev;
    logic             fire_q;
    logic [WIDTH-1:0] fire_sum_q;
    logic             timeout_q;

    logic             cond;
    logic             hit;

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign sum_o = a_q + b_q;

    // Condition is always judged from the registered operands, so a step
    // becomes visible to detection one cycle after it is commanded.
    assign cond = (sum_o == target_q);

    always_comb begin
        hit = 1'b0;
        if (mode_q) hit = cond;
        else        hit = (cond != cond_prev);
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.busy_o    = (state != IDLE);
    assign bus.fire_o    = fire_q;
    assign bus.fire_sum  = fire_sum_q;
    assign bus.timeout_o = timeout_q;

`ifdef COND_WAIT_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q;
`else
    logic unused_timeout_param;
    assign unused_timeout_param = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_q        <= A_INIT;
            b_q        <= B_INIT;
            target_q   <= '0;
            mode_q     <= 1'b0;
            cond_prev  <= 1'b0;
            fire_q     <= 1'b0;
            fire_sum_q <= '0;
            timeout_q  <= 1'b0;
`ifdef COND_WAIT_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            // Operands move in every state; load overrides step.
            if (load) begin
                a_q <= load_a;
                b_q <= load_b;
            end else if (step) begin
                a_q <= a_q + inc_a;
                b_q <= b_q + inc_b;
            end

            case (state)
                IDLE: begin
                    fire_q    <= 1'b0;
                    timeout_q <= 1'b0;
                    if (bus.req_valid) begin
                        target_q  <= bus.req_target;
                        mode_q    <= bus.req_mode;
                        // Baseline for edge mode uses this cycle's operands.
                        cond_prev <= (sum_o == bus.req_target);
                        state     <= ARMED;
`ifdef COND_WAIT_TIMEOUT_EN
                        cnt_q     <= '0;
`endif
                    end
                end
                ARMED: begin
                    cond_prev <= cond;
                    // Priority: detection, then cancel, then timeout.
                    if (hit) begin
                        fire_sum_q <= sum_o;
                        fire_q     <= 1'b1;
                        timeout_q  <= 1'b0;
                        state      <= FIRE;
                    end else if (bus.cancel) begin
                        state <= IDLE;
                    end
`ifdef COND_WAIT_TIMEOUT_EN
                    else if (cnt_q == CNT_LAST) begin
                        fire_sum_q <= sum_o;
                        fire_q     <= 1'b1;
                        timeout_q  <= 1'b1;
                        state      <= FIRE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                FIRE: begin
                    fire_q    <= 1'b0;
                    timeout_q <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    fire_q    <= 1'b0;
                    timeout_q <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
